rx_byte_fifo: RTL and testbench
===============================

Name: rx_byte_fifo

Overview:
Receive-side buffer sitting directly downstream of the UART receive path. It captures each completed frame (8-bit data plus 3-bit error flags [Parity, Start, Stop]) on the rising edge of the receiver's done flag. Frames are stored in a circular FIFO, and the system or bus side drains them through a registered read handshake. The FIFO also reports occupancy and a sticky overrun condition.

Parameters:
DEPTH, 16, number of frame entries; power of two, minimum 2
DATA_W, 8, data width per entry
ERR_W, 3, error-flag width per entry, ordered [Parity, Start, Stop]

Ports:
clock  in  1  system main clock
reset  in  1  asynchronous, active-high reset
done_flag  in  1  frame-complete level from the receiver; may toggle in the baud-clock domain
data_in  in  DATA_W  received data byte; stable while done_flag is high
error_in  in  ERR_W  error flags for the current frame; stable while done_flag is high
rd_en  in  1  pop request
clear_overrun  in  1  clears the sticky overrun flag
rd_valid  out  1  one-cycle pulse: rd_data and rd_error are valid
rd_data  out  DATA_W  popped data byte
rd_error  out  ERR_W  popped error flags
empty  out  1  count == 0
full  out  1  count == DEPTH
count  out  $clog2(DEPTH)+1  current occupancy
overrun_flag  out  1  sticky; a frame was lost

Behaviour:
- Clock and reset: single clock domain (clock). reset is asynchronous, active-high.
- Reset values: all pointers 0, count 0, empty 1, full 0, rd_valid 0, rd_data 0, rd_error 0, overrun_flag 0, synchroniser flops 0.
- done_flag synchroniser: 2 flops (s1, s2), plus a delay flop s3.
- Push strobe: push = s2 & ~s3. One push per done_flag rising edge, regardless of how long the flag stays high.
- Push latency: push asserts on the 3rd clock edge after done_flag rises. data_in and error_in are sampled on that same edge.
- Write: mem[wr_ptr] <= {error_in, data_in}; wr_ptr increments modulo DEPTH.
- Read: rd_en with empty==0 (sampled at edge N) updates rd_data/rd_error from mem[rd_ptr] and asserts rd_valid=1 at edge N+1. rd_ptr increments modulo DEPTH.
- rd_en with empty==1 is ignored: rd_valid stays 0 and rd_data/rd_error hold their last values.
- rd_valid is 0 on any cycle without an accepted pop.
- count update: +1 on push only, -1 on pop only, unchanged on push+pop.
- empty and full are combinational decodes of the registered count.
- Push while full, with no accepted pop in the same cycle: the frame is dropped, memory and pointers are unchanged, overrun_flag <= 1.
- Push while full, with an accepted pop in the same cycle: both succeed and count stays DEPTH.
- Push and pop while empty: the pop is ignored and the push succeeds, so count becomes 1.
- overrun_flag clearing: clear_overrun clears it. If clear_overrun and a new overrun occur in the same cycle, set wins.
- Pointer wrap: pointers are $clog2(DEPTH) bits wide and wrap naturally. Full versus empty is distinguished by count, not by pointer comparison.
- Reset mid-operation: all stored frames are discarded. A done_flag already high when reset deasserts does not produce a push, because s3 tracks s2 after reset.

Optional Feature:
Macro RX_FIFO_DROP_ERR_EN.
- Defined: a push whose error_in != 0 is discarded and never written. A saturating 8-bit output port err_drop_cnt (reset 0) increments on each discard. Discarded frames never set overrun_flag.
- Undefined: every frame is stored with its flags, and the err_drop_cnt port does not exist.

Decomposition:
- Package rx_fifo_pkg holds:
  - the error-bit index constants (ERR_PARITY=2, ERR_START=1, ERR_STOP=0)
  - a packed struct rx_entry_t {err[ERR_W], data[DATA_W]}
- One sub-module is natural: edge_sync_pulse, the 2-flop synchroniser plus rising-edge pulse generator, reusable by the transmit side.
- Storage is an inferred register array inside rx_byte_fifo.

Test Plan:
- Reset, then done_flag rises with data_in=0xA5, error_in=0 -> push on the 3rd edge, count=1, empty=0. rd_en for 1 cycle -> next cycle rd_valid=1, rd_data=0xA5, rd_error=0, count=0.
- done_flag held high for 50 clocks -> exactly one push (count=1).
- 16 frames 0x00..0x0F, then a 17th frame 0xFF with no reads -> full=1, count=16, overrun_flag=1. Draining returns 0x00..0x0F in order, 0xFF never appears. clear_overrun -> overrun_flag=0.
- While full, a push coincides with rd_en -> count stays 16 and overrun_flag stays 0. After 20 interleaved push/pop frames, read order matches write order across pointer wrap.
- rd_en while empty -> rd_valid=0, rd_data keeps its previous value. Reset asserted with count=5 -> count=0 and empty=1 immediately, without waiting for a clock edge.
- With RX_FIFO_DROP_ERR_EN: frame 0x3C with error_in=3'b100 -> not stored, err_drop_cnt=1. Next clean frame 0x3D is read back as 0x3D.

Source files
------------

// File: rtl/rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// rx_fifo_pkg
// Shared types and constants for the UART receive-side frame buffer.
//   RX_DATA_W / RX_ERR_W : default data and error-flag widths of one frame
//   ERR_PARITY/START/STOP: bit positions inside the error-flag field
//   rx_entry_t           : one stored frame, error flags above the data byte
//   frame_bad()          : true when any error flag of a frame is set
// -----------------------------------------------------------------------------
package rx_fifo_pkg;

    localparam int RX_DATA_W = 8;
    localparam int RX_ERR_W  = 3;

    localparam int ERR_PARITY = 2;
    localparam int ERR_START  = 1;
    localparam int ERR_STOP   = 0;

    typedef struct packed {
        logic [RX_ERR_W-1:0]  err;
        logic [RX_DATA_W-1:0] data;
    } rx_entry_t;

    function automatic logic frame_bad(input logic [RX_ERR_W-1:0] e);
        return e[ERR_PARITY] | e[ERR_START] | e[ERR_STOP];
    endfunction

endpackage

// File: rtl/rx_byte_fifo_edge_sync_pulse.sv
// -----------------------------------------------------------------------------
// edge_sync_pulse
// Brings a slow level from another clock domain into clk_i through a 2-flop
// synchroniser (s1, s2) and emits a one-cycle pulse on each rising edge,
// using a third delay flop (s3).
//   clk_i   : destination clock
//   rst_i   : asynchronous active-high reset
//   level_i : asynchronous input level
//   pulse_o : one clk_i cycle high per rising edge of level_i
// -----------------------------------------------------------------------------
module edge_sync_pulse (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic pulse_o
);

    logic       s1_q, s2_q, s3_q;
    // vld_pipe[k] marks that stage k holds a real sample rather than its reset
    // value; a level already high when reset releases is then seen as s2=s3=1
    // and never treated as a fresh edge.
    logic [2:0] vld_pipe;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            vld_pipe <= '0;
        end else begin
            s1_q     <= level_i;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            vld_pipe <= {vld_pipe[1:0], 1'b1};
        end
    end

    assign pulse_o = s2_q & ~s3_q & vld_pipe[2];

endmodule

// File: rtl/rx_byte_fifo.sv
// -----------------------------------------------------------------------------
// rx_byte_fifo
// Receive-side frame buffer behind the UART receiver. A completed frame
// (data + [Parity, Start, Stop] flags) is pushed once per rising edge of
// done_flag and drained by a registered pop handshake.
//   clock, reset        : system clock, asynchronous active-high reset
//   done_flag           : frame-complete level from the receiver (async)
//   data_in, error_in   : frame contents, stable while done_flag is high
//   rd_en               : pop request; ignored while empty
//   clear_overrun       : clears overrun_flag (a same-cycle overrun wins)
//   rd_valid            : one-cycle pulse, rd_data/rd_error hold a popped frame
//   rd_data, rd_error   : last popped frame
//   empty, full, count  : occupancy
//   overrun_flag        : sticky, a frame arrived while full and was lost
//   err_drop_cnt        : only with RX_FIFO_DROP_ERR_EN; saturating count of
//                         frames discarded because error_in was non-zero
// Optional feature macro: RX_FIFO_DROP_ERR_EN.
// DATA_W/ERR_W must match the widths of rx_entry_t in rx_fifo_pkg.
// -----------------------------------------------------------------------------
module rx_byte_fifo import rx_fifo_pkg::*; #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = RX_DATA_W,
    parameter int ERR_W  = RX_ERR_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     done_flag,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [ERR_W-1:0]         error_in,
    input  logic                     rd_en,
    input  logic                     clear_overrun,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [ERR_W-1:0]         rd_error,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun_flag
`ifdef RX_FIFO_DROP_ERR_EN
    ,
    output logic [7:0]               err_drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic            push;
    logic            pop_ok;
    logic            drop_err;
    logic            wr_ok;
    logic            ovf_set;
    rx_entry_t       wr_entry;
    rx_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [ERR_W-1:0]  rd_error_q;
    logic            overrun_q;

    edge_sync_pulse u_done_sync (
        .clk_i   (clock),
        .rst_i   (reset),
        .level_i (done_flag),
        .pulse_o (push)
    );

    assign wr_entry.err  = error_in;
    assign wr_entry.data = data_in;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign pop_ok = rd_en & ~empty;

`ifdef RX_FIFO_DROP_ERR_EN
    logic [7:0] err_drop_cnt_q;

    assign drop_err = push & frame_bad(error_in);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err_drop_cnt_q <= '0;
        else if (drop_err && err_drop_cnt_q != 8'hFF)
            err_drop_cnt_q <= err_drop_cnt_q + 8'd1;
    end

    assign err_drop_cnt = err_drop_cnt_q;
`else
    assign drop_err = 1'b0;
`endif

    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign wr_ok   = push & ~drop_err & (~full | pop_ok);
    assign ovf_set = push & ~drop_err & full & ~pop_ok;

    always_comb begin
        count_d = count_q;
        case ({wr_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; validity is tracked by count and pointers.
    always_ff @(posedge clock) begin
        if (wr_ok)
            mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_error_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_valid_q <= pop_ok;
            if (wr_ok)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok) begin
                // Full with push+pop: wr_ptr == rd_ptr, the old entry is read.
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                rd_data_q  <= mem_q[rd_ptr_q].data;
                rd_error_q <= mem_q[rd_ptr_q].err;
            end
            if (ovf_set)
                overrun_q <= 1'b1;
            else if (clear_overrun)
                overrun_q <= 1'b0;
        end
    end

    assign count        = count_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_error     = rd_error_q;
    assign overrun_flag = overrun_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// -----------------------------------------------------------------------------
// tb_rx_byte_fifo
// Directed bench for rx_byte_fifo: a table of single push/pop frames followed
// by hand-written sequences for latency, long done_flag, overrun, full-cycle
// push+pop, pointer wrap, empty reads, error drop (RX_FIFO_DROP_ERR_EN) and
// asynchronous reset.
// -----------------------------------------------------------------------------
module tb_rx_byte_fifo;
    import rx_fifo_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       done_flag = 1'b0;
    logic [7:0] data_in = '0;
    logic [2:0] error_in = '0;
    logic       rd_en = 1'b0;
    logic       clear_overrun = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [2:0] rd_error;
    logic       empty, full;
    logic [4:0] count;
    logic       overrun_flag;
`ifdef RX_FIFO_DROP_ERR_EN
    logic [7:0] err_drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    rx_byte_fifo #(.DEPTH(16), .DATA_W(8), .ERR_W(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .done_flag     (done_flag),
        .data_in       (data_in),
        .error_in      (error_in),
        .rd_en         (rd_en),
        .clear_overrun (clear_overrun),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_error      (rd_error),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .overrun_flag  (overrun_flag)
`ifdef RX_FIFO_DROP_ERR_EN
        ,
        .err_drop_cnt  (err_drop_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] d;
        logic [2:0] e;
        logic [7:0] exp_d;
        logic [2:0] exp_e;
        logic       exp_par;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Raise done_flag for 4 cycles (push lands on the 3rd edge), then low long
    // enough for the synchroniser to settle before the next frame.
    task automatic push_frame(input logic [7:0] d, input logic [2:0] e);
        @(negedge clock);
        data_in   = d;
        error_in  = e;
        done_flag = 1'b1;
        repeat (4) @(negedge clock);
        done_flag = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic pop_chk(input logic [7:0] d, input logic [2:0] e);
        @(negedge clock);
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        chk("pop rd_valid", rd_valid, 1);
        chk("pop rd_data",  rd_data,  d);
        chk("pop rd_error", rd_error, e);
    endtask

    vec_t       tbl [5];
    logic [7:0] q [$];
    logic [7:0] last_d;

    initial begin
        tbl[0] = '{8'hA5, 3'b000, 8'hA5, 3'b000, 1'b0};
        tbl[1] = '{8'h5A, 3'b100, 8'h5A, 3'b100, 1'b1};
        tbl[2] = '{8'hFF, 3'b010, 8'hFF, 3'b010, 1'b0};
        tbl[3] = '{8'h00, 3'b001, 8'h00, 3'b001, 1'b0};
        tbl[4] = '{8'hC3, 3'b111, 8'hC3, 3'b111, 1'b1};

        // Reset state
        repeat (2) @(negedge clock);
        chk("reset count", count, 0);
        chk("reset empty", empty, 1);
        chk("reset full", full, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset rd_error", rd_error, 0);
        chk("reset overrun", overrun_flag, 0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Push latency: count moves on the 3rd edge after done_flag rises
        data_in = 8'hA5; error_in = 3'b000; done_flag = 1'b1;
        repeat (2) @(negedge clock);
        chk("latency count@2", count, 0);
        @(negedge clock);
        chk("latency count@3", count, 1);
        chk("latency empty", empty, 0);
        @(negedge clock);
        done_flag = 1'b0;
        repeat (3) @(negedge clock);
        pop_chk(8'hA5, 3'b000);
        chk("after pop count", count, 0);
        @(negedge clock);
        chk("rd_valid pulse ends", rd_valid, 0);

        // Table of single frames
        for (int i = 0; i < 5; i++) begin
`ifdef RX_FIFO_DROP_ERR_EN
            if (tbl[i].e != 3'b000) continue;
`endif
            push_frame(tbl[i].d, tbl[i].e);
            chk("tbl count", count, 1);
            pop_chk(tbl[i].exp_d, tbl[i].exp_e);
            chk("tbl parity bit", rd_error[ERR_PARITY], tbl[i].exp_par);
        end

        // done_flag held 50 clocks -> one push
        @(negedge clock);
        data_in = 8'h77; error_in = 3'b000; done_flag = 1'b1;
        repeat (50) @(negedge clock);
        chk("long done count", count, 1);
        done_flag = 1'b0;
        repeat (3) @(negedge clock);
        chk("long done count after", count, 1);
        pop_chk(8'h77, 3'b000);

        // Fill, overrun, drain
        for (int i = 0; i < 16; i++) push_frame(8'(i), 3'b000);
        chk("fill count", count, 16);
        chk("fill full", full, 1);
        chk("fill overrun", overrun_flag, 0);
        push_frame(8'hFF, 3'b000);
        chk("ovf count", count, 16);
        chk("ovf flag", overrun_flag, 1);
        for (int i = 0; i < 16; i++) pop_chk(8'(i), 3'b000);
        chk("drain empty", empty, 1);
        chk("drain count", count, 0);
        chk("ovf sticky", overrun_flag, 1);
        @(negedge clock); clear_overrun = 1'b1;
        @(negedge clock); clear_overrun = 1'b0;
        chk("ovf cleared", overrun_flag, 0);

        // Full + coincident pop/push, then wrap with interleaved traffic
        for (int i = 0; i < 16; i++) begin
            push_frame(8'h80 + 8'(i), 3'b000);
            q.push_back(8'h80 + 8'(i));
        end
        @(negedge clock);
        data_in = 8'h90; error_in = 3'b000; done_flag = 1'b1;
        @(negedge clock);
        @(negedge clock);
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        chk("coinc rd_valid", rd_valid, 1);
        chk("coinc rd_data", rd_data, 8'h80);
        chk("coinc count", count, 16);
        chk("coinc overrun", overrun_flag, 0);
        void'(q.pop_front());
        q.push_back(8'h90);
        @(negedge clock);
        done_flag = 1'b0;
        repeat (3) @(negedge clock);
        chk("coinc overrun later", overrun_flag, 0);
        for (int i = 0; i < 20; i++) begin
            pop_chk(q.pop_front(), 3'b000);
            push_frame(8'hA0 + 8'(i), 3'b000);
            q.push_back(8'hA0 + 8'(i));
        end
        chk("wrap count", count, 16);
        while (q.size() > 0) begin
            last_d = q.pop_front();
            pop_chk(last_d, 3'b000);
        end
        chk("wrap empty", empty, 1);

        // Pop while empty is ignored
        @(negedge clock); rd_en = 1'b1;
        @(negedge clock); rd_en = 1'b0;
        chk("empty pop rd_valid", rd_valid, 0);
        chk("empty pop rd_data", rd_data, last_d);
        chk("empty pop count", count, 0);

`ifdef RX_FIFO_DROP_ERR_EN
        push_frame(8'h3C, 3'b100);
        chk("drop count", count, 0);
        chk("drop cnt", err_drop_cnt, 1);
        chk("drop no overrun", overrun_flag, 0);
        push_frame(8'h3D, 3'b000);
        chk("clean after drop count", count, 1);
        pop_chk(8'h3D, 3'b000);
`endif

        // Asynchronous reset with 5 entries stored
        for (int i = 0; i < 5; i++) push_frame(8'h50 + 8'(i), 3'b000);
        chk("pre-reset count", count, 5);
        @(negedge clock);
        done_flag = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("async reset count", count, 0);
        chk("async reset empty", empty, 1);
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        chk("stale done no push", count, 0);
        done_flag = 1'b0;
        repeat (4) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
